pc_flow_ctrl: RTL and testbench

//  Sequences the fetch PC register: produces its stall, branch_flag and branch_addr

---
 rtl/pc_flow_ctrl_pkg.sv | 30 +++
 rtl/pc_redirect_arb.sv | 50 +++++
 rtl/pc_flow_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pc_flow_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_flow_ctrl_pkg.sv
// Shared types and constants for the fetch-PC flow controller.
// Covers the FSM state encoding, the redirect source codes and the redirect priority ranking.
package pc_flow_ctrl_pkg;

    typedef enum logic [1:0] {
        STATE_BOOT = 2'd0,
        STATE_RUN  = 2'd1,
        STATE_HOLD = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_EXC  = 2'd1,
        SRC_BR   = 2'd2,
        SRC_JMP  = 2'd3
    } src_e;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Higher rank is the older instruction in program order.
    function automatic logic [1:0] src_rank(input src_e s);
        unique case (s)
            SRC_EXC: return 2'd3;
            SRC_BR:  return 2'd2;
            SRC_JMP: return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational priority select among the redirect sources.
// Order is live exception > live EX branch > replayed pending redirect > live ID jump.
module pc_redirect_arb
    import pc_flow_ctrl_pkg::*;
(
    input  logic        excp_v,
    input  logic [31:0] excp_addr,
    input  logic        br_v,
    input  logic [31:0] br_addr,
    input  logic        pend_v,
    input  logic [31:0] pend_addr,
    input  src_e        pend_src,
    input  logic        jmp_v,
    input  logic [31:0] jmp_addr,
    output logic        flag,
    output logic [31:0] addr,
    output src_e        src,
    output logic        full_flush
);

    always_comb begin
        flag       = 1'b0;
        addr       = ZERO_WORD;
        src        = SRC_NONE;
        full_flush = 1'b0;
        if (excp_v) begin
            flag       = 1'b1;
            addr       = excp_addr;
            src        = SRC_EXC;
            full_flush = 1'b1;
        end else if (br_v) begin
            flag       = 1'b1;
            addr       = br_addr;
            src        = SRC_BR;
            full_flush = 1'b1;
        end else if (pend_v) begin
            // A replayed redirect squashes both stages whatever its origin.
            flag       = 1'b1;
            addr       = pend_addr;
            src        = pend_src;
            full_flush = 1'b1;
        end else if (jmp_v) begin
            flag       = 1'b1;
            addr       = jmp_addr;
            src        = SRC_JMP;
            full_flush = 1'b0;
        end
    end

endmodule

// File: rtl/pc_flow_ctrl.sv
// Fetch-PC sequencer: stall / redirect / flush generation with boot, hazard and
// multi-cycle holds, buffering redirects that arrive during a hold.
module pc_flow_ctrl
    import pc_flow_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned MEM_WAIT   = 2,
    parameter int unsigned CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inited,
    input  logic        excp_req,
    input  logic [31:0] excp_vec,
    input  logic        br_req,
    input  logic [31:0] br_target,
    input  logic        jmp_req,
    input  logic [31:0] jmp_target,
    input  logic        load_use,
    input  logic        div_start,
    input  logic        mem_req,
    output logic        stall,
    output logic        branch_flag,
    output logic [31:0] branch_addr,
    output logic        flush_if,
    output logic        flush_id,
    output logic        busy
);

    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEM_M1 = CNT_W'(MEM_WAIT - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             pend_v;
    logic [31:0]      pend_addr;
    src_e             pend_src;

    logic             in_boot;
    logic             in_run;
    logic             in_hold;
    logic             hold_issue;
    logic             live_ok;
    logic             excp_hit;
    logic [CNT_W-1:0] hold_len_m1;

    logic             arb_flag;
    logic [31:0]      arb_addr;
    src_e             arb_src;
    logic             arb_full;

    logic             capture;
    logic             overwrite;
    src_e             cap_src;
    logic [31:0]      cap_addr;

    assign in_boot    = (state == STATE_BOOT);
    assign in_run     = (state == STATE_RUN);
    assign in_hold    = (state == STATE_HOLD);
    assign hold_issue = in_run & (div_start | mem_req);
    assign live_ok    = in_run & ~hold_issue;
    assign excp_hit   = excp_req & ~in_boot;

    always_comb begin
        hold_len_m1 = MEM_M1;
        if (div_start && mem_req) begin
            hold_len_m1 = (DIV_M1 > MEM_M1) ? DIV_M1 : MEM_M1;
        end else if (div_start) begin
            hold_len_m1 = DIV_M1;
        end
    end

    pc_redirect_arb u_arb (
        .excp_v     (excp_hit),
        .excp_addr  (excp_vec),
        .br_v       (br_req & live_ok),
        .br_addr    (br_target),
        .pend_v     (pend_v & live_ok),
        .pend_addr  (pend_addr),
        .pend_src   (pend_src),
        .jmp_v      (jmp_req & live_ok),
        .jmp_addr   (jmp_target),
        .flag       (arb_flag),
        .addr       (arb_addr),
        .src        (arb_src),
        .full_flush (arb_full)
    );

    // Redirects seen while fetch is held are parked; an older source replaces a younger one.
    assign capture   = (in_hold | hold_issue) & ~excp_hit & (br_req | jmp_req);
    assign cap_src   = br_req ? SRC_BR : SRC_JMP;
    assign cap_addr  = br_req ? br_target : jmp_target;
    assign overwrite = capture & (~pend_v | (src_rank(cap_src) > src_rank(pend_src)));

    always_comb begin
        branch_flag = arb_flag;
        branch_addr = arb_addr;
        flush_if    = (arb_src != SRC_NONE);
        flush_id    = (arb_flag & arb_full) | (in_run & load_use & ~arb_flag);
        stall       = ~arb_flag & (in_boot | in_hold | hold_issue | (in_run & load_use));
        busy        = in_hold;
    end

    // cnt holds the HOLD cycles still to run; the issuing RUN cycle is the first stall cycle,
    // so HOLD is left at the edge where the last counted cycle retires (cnt reaching zero).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= STATE_BOOT;
            cnt       <= '0;
            pend_v    <= 1'b0;
            pend_addr <= ZERO_WORD;
            pend_src  <= SRC_NONE;
        end else if (!inited) begin
            state  <= STATE_BOOT;
            cnt    <= '0;
            pend_v <= 1'b0;
        end else begin
            unique case (state)
                STATE_BOOT: begin
                    state <= STATE_RUN;
                end
                STATE_RUN: begin
                    if (excp_req) begin
                        cnt    <= '0;
                        pend_v <= 1'b0;
                    end else if (hold_issue) begin
                        if (hold_len_m1 != '0) begin
                            state <= STATE_HOLD;
                            cnt   <= hold_len_m1;
                        end
                    end else begin
                        pend_v <= 1'b0;
                    end
                end
                STATE_HOLD: begin
                    if (excp_req) begin
                        state  <= STATE_RUN;
                        cnt    <= '0;
                        pend_v <= 1'b0;
                    end else if (cnt <= CNT_W'(1)) begin
                        state <= STATE_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= STATE_BOOT;
                    cnt   <= '0;
                end
            endcase
            if (overwrite) begin
                pend_v    <= 1'b1;
                pend_addr <= cap_addr;
                pend_src  <= cap_src;
            end
        end
    end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Bench for pc_flow_ctrl: behavioural model checked every cycle, plus directed literal checks.
module tb_pc_flow_ctrl;

    localparam int DIV_N = 32;
    localparam int MEM_N = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        inited;
    logic        excp_req;
    logic [31:0] excp_vec;
    logic        br_req;
    logic [31:0] br_target;
    logic        jmp_req;
    logic [31:0] jmp_target;
    logic        load_use;
    logic        div_start;
    logic        mem_req;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_addr;
    logic        flush_if;
    logic        flush_id;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_flow_ctrl #(
        .DIV_CYCLES (DIV_N),
        .MEM_WAIT   (MEM_N),
        .CNT_W      (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inited      (inited),
        .excp_req    (excp_req),
        .excp_vec    (excp_vec),
        .br_req      (br_req),
        .br_target   (br_target),
        .jmp_req     (jmp_req),
        .jmp_target  (jmp_target),
        .load_use    (load_use),
        .div_start   (div_start),
        .mem_req     (mem_req),
        .stall       (stall),
        .branch_flag (branch_flag),
        .branch_addr (branch_addr),
        .flush_if    (flush_if),
        .flush_id    (flush_id),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int hold_total(input logic d, input logic m);
        int t;
        t = 0;
        if (d && DIV_N > t) t = DIV_N;
        if (m && MEM_N > t) t = MEM_N;
        return t;
    endfunction

    // Model: booting flag, number of stalled cycles still owed after the issuing one,
    // and a one-entry parked redirect.
    logic        m_boot;
    int          m_owed;
    logic        m_pend;
    logic [31:0] m_pend_addr;
    logic        m_pend_br;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_boot      <= 1'b1;
            m_owed      <= 0;
            m_pend      <= 1'b0;
            m_pend_addr <= 32'h0;
            m_pend_br   <= 1'b0;
        end else if (!inited) begin
            m_boot <= 1'b1;
            m_owed <= 0;
            m_pend <= 1'b0;
        end else if (m_boot) begin
            m_boot <= 1'b0;
        end else if (excp_req) begin
            m_owed <= 0;
            m_pend <= 1'b0;
        end else if (m_owed > 0 || div_start || mem_req) begin
            if (m_owed > 0) m_owed <= m_owed - 1;
            else m_owed <= hold_total(div_start, mem_req) - 1;
            if ((br_req || jmp_req) && (!m_pend || (br_req && !m_pend_br))) begin
                m_pend      <= 1'b1;
                m_pend_addr <= br_req ? br_target : jmp_target;
                m_pend_br   <= br_req;
            end
        end else begin
            m_pend <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic        e_stall, e_flag, e_fif, e_fid, e_busy;
        logic [31:0] e_addr;
        e_stall = 0; e_flag = 0; e_fif = 0; e_fid = 0; e_busy = 0; e_addr = 32'h0;
        if (m_boot) begin
            e_stall = 1;
        end else begin
            e_busy = (m_owed > 0);
            if (excp_req) begin
                e_flag = 1; e_addr = excp_vec; e_fif = 1; e_fid = 1;
            end else if (m_owed > 0) begin
                e_stall = 1;
            end else if (div_start || mem_req) begin
                e_stall = 1; e_fid = load_use;
            end else if (br_req) begin
                e_flag = 1; e_addr = br_target; e_fif = 1; e_fid = 1;
            end else if (m_pend) begin
                e_flag = 1; e_addr = m_pend_addr; e_fif = 1; e_fid = 1;
            end else if (jmp_req) begin
                e_flag = 1; e_addr = jmp_target; e_fif = 1;
            end else if (load_use) begin
                e_stall = 1; e_fid = 1;
            end
        end
        check("model.stall", {31'b0, stall}, {31'b0, e_stall});
        check("model.branch_flag", {31'b0, branch_flag}, {31'b0, e_flag});
        check("model.branch_addr", branch_addr, e_addr);
        check("model.flush_if", {31'b0, flush_if}, {31'b0, e_fif});
        check("model.flush_id", {31'b0, flush_id}, {31'b0, e_fid});
        check("model.busy", {31'b0, busy}, {31'b0, e_busy});
    end

    task automatic clear_reqs();
        excp_req = 0; br_req = 0; jmp_req = 0; load_use = 0; div_start = 0; mem_req = 0;
        excp_vec = 32'h0; br_target = 32'h0; jmp_target = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stall_n;
        int busy_n;
        rst = 1; inited = 0;
        clear_reqs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.stall", {31'b0, stall}, 32'd1);
        check("reset.branch_flag", {31'b0, branch_flag}, 32'd0);
        check("reset.busy", {31'b0, busy}, 32'd0);
        tick();
        rst = 0;

        // Boot hold
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("boot.stall", {31'b0, stall}, 32'd1);
            check("boot.branch_flag", {31'b0, branch_flag}, 32'd0);
            tick();
        end
        inited = 1;
        @(negedge clk);
        check("boot.last_stall", {31'b0, stall}, 32'd1);
        tick();
        @(negedge clk);
        check("run.stall", {31'b0, stall}, 32'd0);

        // Branch beats jump in the same cycle
        tick();
        br_req = 1; br_target = 32'h40; jmp_req = 1; jmp_target = 32'h80;
        @(negedge clk);
        check("br_vs_jmp.flag", {31'b0, branch_flag}, 32'd1);
        check("br_vs_jmp.addr", branch_addr, 32'h40);
        check("br_vs_jmp.flush_if", {31'b0, flush_if}, 32'd1);
        check("br_vs_jmp.flush_id", {31'b0, flush_id}, 32'd1);
        tick();
        clear_reqs();

        // Divide: exactly DIV_N stall cycles, DIV_N-1 busy
        div_start = 1;
        stall_n = 0; busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            stall_n += int'(stall);
            busy_n += int'(busy);
            tick();
            div_start = 0;
        end
        check("div.stall_cycles", stall_n, 32'd32);
        check("div.busy_cycles", busy_n, 32'd31);

        // Memory wait with a jump parked during the hold
        mem_req = 1;
        @(negedge clk);
        check("mem.issue_stall", {31'b0, stall}, 32'd1);
        tick();
        mem_req = 0; jmp_req = 1; jmp_target = 32'h100;
        @(negedge clk);
        check("mem.hold_flag", {31'b0, branch_flag}, 32'd0);
        check("mem.hold_busy", {31'b0, busy}, 32'd1);
        tick();
        clear_reqs();
        @(negedge clk);
        check("mem.replay_flag", {31'b0, branch_flag}, 32'd1);
        check("mem.replay_addr", branch_addr, 32'h100);
        check("mem.replay_flush_id", {31'b0, flush_id}, 32'd1);
        tick();
        @(negedge clk);
        check("mem.after_flag", {31'b0, branch_flag}, 32'd0);
        tick();

        // Exception aborts a divide on the 5th hold cycle; parked branch is dropped
        div_start = 1;
        tick();
        div_start = 0;
        for (int h = 1; h <= 5; h++) begin
            br_req = (h == 2); br_target = 32'h300;
            excp_req = (h == 5); excp_vec = 32'h8;
            if (h < 5) tick();
        end
        @(negedge clk);
        check("excp.flag", {31'b0, branch_flag}, 32'd1);
        check("excp.addr", branch_addr, 32'h8);
        check("excp.stall", {31'b0, stall}, 32'd0);
        tick();
        clear_reqs();
        @(negedge clk);
        check("excp.next_stall", {31'b0, stall}, 32'd0);
        check("excp.next_busy", {31'b0, busy}, 32'd0);
        check("excp.pend_dropped", {31'b0, branch_flag}, 32'd0);
        tick();

        // Load-use bubble, then load-use overridden by a branch
        load_use = 1;
        @(negedge clk);
        check("lu.stall", {31'b0, stall}, 32'd1);
        check("lu.flush_id", {31'b0, flush_id}, 32'd1);
        check("lu.flush_if", {31'b0, flush_if}, 32'd0);
        tick();
        load_use = 0;
        @(negedge clk);
        check("lu.release", {31'b0, stall}, 32'd0);
        tick();
        load_use = 1; br_req = 1; br_target = 32'h200;
        @(negedge clk);
        check("lu_br.flag", {31'b0, branch_flag}, 32'd1);
        check("lu_br.stall", {31'b0, stall}, 32'd0);
        check("lu_br.addr", branch_addr, 32'h200);
        tick();
        clear_reqs();

        // Mixed traffic, model-checked only
        for (int i = 0; i < 400; i++) begin
            inited     = ($urandom_range(63) != 0);
            excp_req   = ($urandom_range(15) == 0);
            br_req     = ($urandom_range(5) == 0);
            jmp_req    = ($urandom_range(5) == 0);
            load_use   = ($urandom_range(5) == 0);
            div_start  = ($urandom_range(47) == 0);
            mem_req    = ($urandom_range(9) == 0);
            excp_vec   = {$urandom_range(255), 2'b00};
            br_target  = {$urandom_range(4095), 2'b00};
            jmp_target = {$urandom_range(4095), 2'b00};
            tick();
        end
        clear_reqs();
        inited = 1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
